io_bus_arbiter: RTL and testbench



---
 rtl/io_bus_arbiter_pkg.sv | 21 ++
 rtl/io_bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_io_bus_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_bus_arbiter_pkg.sv
// Shared definitions for the two-port I/O bus arbiter: bus widths, strobe limit,
// sequencer state encoding and the round-robin pick.
package io_bus_arbiter_pkg;

   localparam int ADDR_W     = 16;
   localparam int DATA_W     = 8;
   localparam int STROBE_MAX = 15;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   // A tie goes to the port that was not served last.
   function automatic logic pick_port(input logic req0, input logic req1, input logic last);
      return (req0 && req1) ? ~last : req1;
   endfunction

endpackage

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter and setup/strobe/hold sequencer for the shared 8-bit I/O bus.
// Each granted request runs one full bus cycle and is acknowledged with a single-cycle pulse.
module io_bus_arbiter
   import io_bus_arbiter_pkg::*;
#(
   parameter int P_STROBE = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] addr,
   inout  wire  [DATA_W-1:0] data,
   output logic              ior_,
   output logic              iow_
);

   localparam logic [3:0] STROBE_LOAD = 4'(P_STROBE - 1);

   state_t            state_q, state_d;
   logic              gnt_q, gnt_d;
   logic              last_q, last_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              dir_q, dir_d;
   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic              ior_n_q, ior_n_d;
   logic              iow_n_q, iow_n_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              pick;

   assign pick = pick_port(req0, req1, last_q);

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      dir_d      = dir_q;
      data_out_d = data_out_q;
      addr_d     = addr_q;
      we_d       = we_q;
      ior_n_d    = ior_n_q;
      iow_n_d    = iow_n_q;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;

      unique case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               gnt_d      = pick;
               addr_d     = pick ? addr1 : addr0;
               we_d       = pick ? we1 : we0;
               data_out_d = pick ? wdata1 : wdata0;
               dir_d      = pick ? we1 : we0;
               cnt_d      = STROBE_LOAD;
               state_d    = SETUP;
            end
         end
         SETUP: begin
            if (we_q) iow_n_d = 1'b0;
            else      ior_n_d = 1'b0;
            state_d = STROBE;
         end
         STROBE: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               ior_n_d = 1'b1;
               iow_n_d = 1'b1;
               // Read data is sampled on the same edge that releases the strobe.
               if (!we_q) begin
                  if (gnt_q) rdata1_d = data;
                  else       rdata0_d = data;
               end
               if (gnt_q) ack1_d = 1'b1;
               else       ack0_d = 1'b1;
               last_d  = gnt_q;
               state_d = HOLD;
            end
         end
         HOLD: begin
            dir_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         gnt_q      <= 1'b0;
         last_q     <= 1'b1;
         cnt_q      <= 4'd0;
         dir_q      <= 1'b0;
         data_out_q <= '0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         ior_n_q    <= 1'b1;
         iow_n_q    <= 1'b1;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         dir_q      <= dir_d;
         data_out_q <= data_out_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         ior_n_q    <= ior_n_d;
         iow_n_q    <= iow_n_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
      end
   end

   assign data   = dir_q ? data_out_q : {DATA_W{1'bz}};
   assign addr   = addr_q;
   assign ior_   = ior_n_q;
   assign iow_   = iow_n_q;
   assign ack0   = ack0_q;
   assign ack1   = ack1_q;
   assign rdata0 = rdata0_q;
   assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: a P_STROBE=3 instance driven through per-port
// requester queues with an ack scoreboard, plus P_STROBE=1 and P_STROBE=15 single-read instances.
module tb_io_bus_arbiter;

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wdata;
   } txn_t;

   typedef struct packed {
      logic       port;
      logic       is_read;
      logic [7:0] rdata;
      int         cyc;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   checks   = 0;
   int   failures = 0;

   // Bus peripheral model: read value is a fixed function of the address.
   function automatic logic [7:0] bus_byte(input logic [15:0] a);
      return a[15:8] ^ a[7:0] ^ 8'h7B;
   endfunction

   // Main instance (P_STROBE=3)
   logic        req0_m = 1'b0, req1_m = 1'b0, we0_m = 1'b0, we1_m = 1'b0;
   logic [15:0] addr0_m = '0, addr1_m = '0;
   logic [7:0]  wdata0_m = '0, wdata1_m = '0;
   logic        ack0_m, ack1_m, ior_m, iow_m;
   logic [7:0]  rdata0_m, rdata1_m;
   logic [15:0] addr_m;
   wire  [7:0]  data_m;
   assign data_m = (!ior_m) ? bus_byte(addr_m) : 8'hzz;

   io_bus_arbiter #(.P_STROBE(3)) dut_m (
      .clock(clock), .reset(reset),
      .req0(req0_m), .req1(req1_m), .we0(we0_m), .we1(we1_m),
      .addr0(addr0_m), .addr1(addr1_m), .wdata0(wdata0_m), .wdata1(wdata1_m),
      .ack0(ack0_m), .ack1(ack1_m), .rdata0(rdata0_m), .rdata1(rdata1_m),
      .addr(addr_m), .data(data_m), .ior_(ior_m), .iow_(iow_m)
   );

   // Short-strobe instance (P_STROBE=1)
   logic        req0_s = 1'b0;
   logic [15:0] addr0_s = '0;
   logic        ack0_s, ack1_s, ior_s, iow_s;
   logic [7:0]  rdata0_s, rdata1_s;
   logic [15:0] addr_s;
   wire  [7:0]  data_s;
   assign data_s = (!ior_s) ? bus_byte(addr_s) : 8'hzz;

   io_bus_arbiter #(.P_STROBE(1)) dut_s (
      .clock(clock), .reset(reset),
      .req0(req0_s), .req1(1'b0), .we0(1'b0), .we1(1'b0),
      .addr0(addr0_s), .addr1(16'h0000), .wdata0(8'h00), .wdata1(8'h00),
      .ack0(ack0_s), .ack1(ack1_s), .rdata0(rdata0_s), .rdata1(rdata1_s),
      .addr(addr_s), .data(data_s), .ior_(ior_s), .iow_(iow_s)
   );

   // Long-strobe instance (P_STROBE=15)
   logic        req0_l = 1'b0;
   logic [15:0] addr0_l = '0;
   logic        ack0_l, ack1_l, ior_l, iow_l;
   logic [7:0]  rdata0_l, rdata1_l;
   logic [15:0] addr_l;
   wire  [7:0]  data_l;
   assign data_l = (!ior_l) ? bus_byte(addr_l) : 8'hzz;

   io_bus_arbiter #(.P_STROBE(15)) dut_l (
      .clock(clock), .reset(reset),
      .req0(req0_l), .req1(1'b0), .we0(1'b0), .we1(1'b0),
      .addr0(addr0_l), .addr1(16'h0000), .wdata0(8'h00), .wdata1(8'h00),
      .ack0(ack0_l), .ack1(ack1_l), .rdata0(rdata0_l), .rdata1(rdata1_l),
      .addr(addr_l), .data(data_l), .ior_(ior_l), .iow_(iow_l)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc = cyc + 1;

   txn_t mq0[$];
   txn_t mq1[$];
   exp_t sb[$];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks = checks + 1;
      if (actual !== expected) begin
         failures = failures + 1;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Requesters present the head of their queue and hold req until it is acked.
   task automatic presentPorts();
      req0_m = (mq0.size() > 0);
      req1_m = (mq1.size() > 0);
      if (mq0.size() > 0) {we0_m, addr0_m, wdata0_m} = mq0[0];
      if (mq1.size() > 0) {we1_m, addr1_m, wdata1_m} = mq1[0];
   endtask

   task automatic applyStimulus(input logic port, input logic we, input logic [15:0] a, input logic [7:0] wd);
      txn_t t;
      t.we = we; t.addr = a; t.wdata = wd;
      if (port) mq1.push_back(t);
      else      mq0.push_back(t);
      presentPorts();
   endtask

   task automatic expectAck(input logic port, input logic is_read, input logic [7:0] rd, input int at_cyc);
      exp_t e;
      e.port = port; e.is_read = is_read; e.rdata = rd; e.cyc = at_cyc;
      sb.push_back(e);
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         if (ack0_m && mq0.size() > 0) begin
            void'(mq0.pop_front());
            presentPorts();
         end
         if (ack1_m && mq1.size() > 0) begin
            void'(mq1.pop_front());
            presentPorts();
         end
      end
   end

   // Monitor: every ack pops the scoreboard and is compared for port, timing and read data.
   always @(negedge clock) begin
      exp_t e;
      if (!ior_m || !iow_m)
         checkOutput("strobe_exclusive", {31'd0, ior_m | iow_m}, 32'd1);
      if (ack0_m || ack1_m) begin
         if (sb.size() == 0) begin
            checkOutput("ack_unexpected", {30'd0, ack1_m, ack0_m}, 32'd0);
         end else begin
            e = sb.pop_front();
            checkOutput("ack_port", {30'd0, ack1_m, ack0_m}, e.port ? 32'd2 : 32'd1);
            checkOutput("ack_cycle", cyc, e.cyc);
            if (e.is_read)
               checkOutput("ack_rdata", e.port ? {24'd0, rdata1_m} : {24'd0, rdata0_m}, {24'd0, e.rdata});
         end
      end
   end

   // Per-cycle strobe/address/data expectations for one isolated P_STROBE=3 transaction.
   task automatic checkCycle(input int k, input logic we, input logic [15:0] a, input logic [7:0] wd);
      logic strobe_low;
      strobe_low = (k >= 2) && (k <= 4);
      checkOutput($sformatf("ior_k%0d", k), {31'd0, ior_m}, {31'd0, !(strobe_low && !we)});
      checkOutput($sformatf("iow_k%0d", k), {31'd0, iow_m}, {31'd0, !(strobe_low && we)});
      if (k <= 5) checkOutput($sformatf("addr_k%0d", k), {16'd0, addr_m}, {16'd0, a});
      if (we && k <= 5) checkOutput($sformatf("wdata_k%0d", k), {24'd0, data_m}, {24'd0, wd});
      if (we && k == 6) checkOutput("data_released", {31'd0, data_m !== wd}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base;
      int base2;
      int low_cnt;
      int ack_k;
      int ack_cnt;

      repeat (3) @(negedge clock);
      checkOutput("rst_ior", {31'd0, ior_m}, 32'd1);
      checkOutput("rst_iow", {31'd0, iow_m}, 32'd1);
      checkOutput("rst_addr", {16'd0, addr_m}, 32'd0);
      checkOutput("rst_ack", {30'd0, ack1_m, ack0_m}, 32'd0);
      checkOutput("rst_rdata0", {24'd0, rdata0_m}, 32'd0);
      checkOutput("rst_rdata1", {24'd0, rdata1_m}, 32'd0);
      reset = 1'b0;
      @(negedge clock);

      $display("[TB] single read, port 0");
      base = cyc;
      expectAck(1'b0, 1'b1, 8'h5A, base + 5);
      applyStimulus(1'b0, 1'b0, 16'h0120, 8'h00);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clock);
         checkCycle(k, 1'b0, 16'h0120, 8'h00);
      end

      $display("[TB] single write, port 1");
      base = cyc;
      expectAck(1'b1, 1'b0, 8'h00, base + 5);
      applyStimulus(1'b1, 1'b1, 16'h0140, 8'hC3);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clock);
         checkCycle(k, 1'b1, 16'h0140, 8'hC3);
      end

      $display("[TB] both ports requesting continuously");
      base = cyc;
      expectAck(1'b0, 1'b1, 8'h79, base + 5);
      expectAck(1'b1, 1'b0, 8'h00, base + 11);
      expectAck(1'b0, 1'b0, 8'h00, base + 17);
      expectAck(1'b1, 1'b1, 8'h69, base + 23);
      applyStimulus(1'b0, 1'b0, 16'h0200, 8'h00);
      applyStimulus(1'b0, 1'b1, 16'h0210, 8'h11);
      applyStimulus(1'b1, 1'b1, 16'h0300, 8'h22);
      applyStimulus(1'b1, 1'b0, 16'h0311, 8'h00);
      for (int k = 1; k <= 24; k++) begin
         @(negedge clock);
         if (k == 8) begin
            checkOutput("rr_addr2", {16'd0, addr_m}, 32'h0300);
            checkOutput("rr_wdata2", {24'd0, data_m}, 32'h22);
            checkOutput("rr_iow2", {31'd0, iow_m}, 32'd0);
         end
         if (k == 12) checkOutput("rr_idle_released", {31'd0, data_m !== 8'h22}, 32'd1);
      end

      $display("[TB] port 1 requests during port 0 strobe");
      base = cyc;
      expectAck(1'b0, 1'b1, 8'h5A, base + 5);
      expectAck(1'b1, 1'b1, 8'h2A, base + 11);
      applyStimulus(1'b0, 1'b0, 16'h0120, 8'h00);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clock);
         if (k <= 6) checkCycle(k, 1'b0, 16'h0120, 8'h00);
         if (k == 3) applyStimulus(1'b1, 1'b0, 16'h0455, 8'h00);
      end

      base = cyc;
      expectAck(1'b0, 1'b1, 8'h5A, base + 5);
      applyStimulus(1'b0, 1'b0, 16'h0120, 8'h00);
      repeat (6) @(negedge clock);

      $display("[TB] reset during write strobe");
      applyStimulus(1'b0, 1'b1, 16'h0500, 8'h5E);
      repeat (3) @(negedge clock);
      checkOutput("pre_rst_iow", {31'd0, iow_m}, 32'd0);
      checkOutput("pre_rst_data", {24'd0, data_m}, 32'h5E);
      reset = 1'b1;
      applyStimulus(1'b1, 1'b0, 16'h0600, 8'h00);
      #1;
      checkOutput("mid_rst_iow", {31'd0, iow_m}, 32'd1);
      checkOutput("mid_rst_ior", {31'd0, ior_m}, 32'd1);
      checkOutput("mid_rst_released", {31'd0, data_m !== 8'h5E}, 32'd1);
      checkOutput("mid_rst_addr", {16'd0, addr_m}, 32'd0);
      @(negedge clock);
      checkOutput("mid_rst_ack", {30'd0, ack1_m, ack0_m}, 32'd0);
      reset = 1'b0;
      base2 = cyc;
      expectAck(1'b0, 1'b0, 8'h00, base2 + 5);
      expectAck(1'b1, 1'b1, 8'h7D, base2 + 11);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clock);
         if (k == 2) checkOutput("post_rst_wdata", {24'd0, data_m}, 32'h5E);
      end
      checkOutput("sb_empty", sb.size(), 32'd0);

      $display("[TB] P_STROBE=1 read");
      base = cyc;
      req0_s  = 1'b1;
      addr0_s = 16'h0120;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clock);
         checkOutput($sformatf("s_iow_k%0d", k), {31'd0, iow_s}, 32'd1);
         checkOutput($sformatf("s_ior_k%0d", k), {31'd0, ior_s}, (k == 2) ? 32'd0 : 32'd1);
         checkOutput($sformatf("s_ack_k%0d", k), {31'd0, ack0_s}, (k == 3) ? 32'd1 : 32'd0);
         if (k == 3) begin
            checkOutput("s_rdata0", {24'd0, rdata0_s}, 32'h5A);
            req0_s = 1'b0;
         end
      end

      $display("[TB] P_STROBE=15 read");
      req0_l  = 1'b1;
      addr0_l = 16'h0777;
      low_cnt = 0;
      ack_k   = 0;
      ack_cnt = 0;
      for (int k = 1; k <= 19; k++) begin
         @(negedge clock);
         if (!ior_l) low_cnt = low_cnt + 1;
         if (ack0_l) begin
            ack_cnt = ack_cnt + 1;
            ack_k   = k;
            req0_l  = 1'b0;
         end
      end
      checkOutput("l_ior_low_cycles", low_cnt, 32'd15);
      checkOutput("l_ack_cycle", ack_k, 32'd17);
      checkOutput("l_ack_count", ack_cnt, 32'd1);
      checkOutput("l_rdata0", {24'd0, rdata0_l}, 32'h0B);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
